// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory arbiter: line geometry,
// arbiter FSM states and requester identifiers.
package mem_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and latency sequencer in front of the single-port
// line-wide main memory. Grants icache refills and dcache refill/write-back
// requests, emulates a fixed memory latency and returns a one-cycle ready
// pulse with the line to the winning requester. Every output is a register
// loaded from the next-state values, so no request input reaches an output
// combinationally.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = mem_pkg::ADDR_W,
  parameter int unsigned LINE_W      = mem_pkg::LINE_W,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [LINE_W-1:0] mem_rdata
);

  import mem_pkg::*;

  // Counter load value: the last BUSY cycle is the one with cnt == 0.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  // Transaction state
  arb_state_t        state_r,      state_s;
  logic [3:0]        cnt_r,        cnt_s;
  req_id_t           last_grant_r, last_grant_s;
  req_id_t           id_r,         id_s;
  logic [ADDR_W-1:0] addr_r,       addr_s;
  logic              we_r,         we_s;
  logic [LINE_W-1:0] wdata_r,      wdata_s;
  logic [LINE_W-1:0] resp_r,       resp_s;

  // Next values of the registered outputs
  logic              grant_dc_s;
  logic              busy_nx_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [LINE_W-1:0] mem_wdata_s;
  logic              mem_we_s;
  logic              ic_ready_s;
  logic              dc_ready_s;
  logic [LINE_W-1:0] ic_rdata_s;
  logic [LINE_W-1:0] dc_rdata_s;

  // Output registers
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] mem_waddr_r;
  logic [LINE_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              ic_ready_r;
  logic              dc_ready_r;
  logic [LINE_W-1:0] ic_rdata_r;
  logic [LINE_W-1:0] dc_rdata_r;

  // Round-robin pick: DC wins when alone, or on a tie when IC had the last grant.
  assign grant_dc_s = dc_req && (!ic_req || (last_grant_r == REQ_IC));

  // FSM next-state, request latching and response capture.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    id_s         = id_r;
    addr_s       = addr_r;
    we_s         = we_r;
    wdata_s      = wdata_r;
    resp_s       = resp_r;
    case (state_r)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_s      = BUSY;
          cnt_s        = CNT_LOAD;
          last_grant_s = grant_dc_s ? REQ_DC : REQ_IC;
          id_s         = grant_dc_s ? REQ_DC : REQ_IC;
          addr_s       = grant_dc_s ? dc_addr : ic_addr;
          we_s         = grant_dc_s ? dc_we : 1'b0;
          wdata_s      = grant_dc_s ? dc_wdata : {LINE_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          state_s = RESP;
          resp_s  = we_r ? {LINE_W{1'b0}} : mem_rdata;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state and next latched values only.
  always_comb begin
    busy_nx_s   = (state_s == BUSY);
    mem_addr_s  = busy_nx_s ? addr_s : {ADDR_W{1'b0}};
    mem_wdata_s = busy_nx_s ? wdata_s : {LINE_W{1'b0}};
    mem_we_s    = busy_nx_s && (cnt_s == 4'd0) && we_s;
    ic_ready_s  = (state_s == RESP) && (id_s == REQ_IC);
    dc_ready_s  = (state_s == RESP) && (id_s == REQ_DC);
    ic_rdata_s  = ic_ready_s ? resp_s : {LINE_W{1'b0}};
    dc_rdata_s  = dc_ready_s ? resp_s : {LINE_W{1'b0}};
  end

  // State, latched request and output registers; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      last_grant_r <= REQ_DC;
      id_r         <= REQ_IC;
      addr_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      wdata_r      <= {LINE_W{1'b0}};
      resp_r       <= {LINE_W{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_waddr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {LINE_W{1'b0}};
      mem_we_r     <= 1'b0;
      ic_ready_r   <= 1'b0;
      dc_ready_r   <= 1'b0;
      ic_rdata_r   <= {LINE_W{1'b0}};
      dc_rdata_r   <= {LINE_W{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      id_r         <= id_s;
      addr_r       <= addr_s;
      we_r         <= we_s;
      wdata_r      <= wdata_s;
      resp_r       <= resp_s;
      mem_addr_r   <= mem_addr_s;
      mem_waddr_r  <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_we_r     <= mem_we_s;
      ic_ready_r   <= ic_ready_s;
      dc_ready_r   <= dc_ready_s;
      ic_rdata_r   <= ic_rdata_s;
      dc_rdata_r   <= dc_rdata_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_waddr = mem_waddr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign ic_ready  = ic_ready_r;
  assign dc_ready  = dc_ready_r;
  assign ic_rdata  = ic_rdata_r;
  assign dc_rdata  = dc_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at latency 4 and one at latency 1,
// each with its own line memory. Only one instance runs at a time; the
// other is held in reset. Expected behaviour comes from a transaction-level
// model: round-robin winner from the last granted port, fixed latency
// arithmetic, and a reference copy of memory contents.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset4, reset1, preload;
  logic         ic_req, dc_req, dc_we;
  logic [25:0]  ic_addr, dc_addr;
  logic [127:0] dc_wdata;

  logic         ic_ready4, dc_ready4, mem_we4, ic_ready1, dc_ready1, mem_we1;
  logic [127:0] ic_rdata4, dc_rdata4, mem_wdata4, mem_rdata4;
  logic [127:0] ic_rdata1, dc_rdata1, mem_wdata1, mem_rdata1;
  logic [25:0]  mem_addr4, mem_waddr4, mem_addr1, mem_waddr1;

  logic [127:0] mem4 [256];
  logic [127:0] mem1 [256];
  logic [127:0] ref_mem [256];

  int  checks = 0;
  int  errors = 0;
  bit  sel1 = 1'b0;   // 1 = latency-1 instance under test
  bit  last_dc;       // model: last granted port was DC

  mem_arbiter #(.ADDR_W(26), .LINE_W(128), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset4),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready4), .ic_rdata(ic_rdata4),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready4), .dc_rdata(dc_rdata4),
    .mem_addr(mem_addr4), .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
    .mem_we(mem_we4), .mem_rdata(mem_rdata4));

  mem_arbiter #(.ADDR_W(26), .LINE_W(128), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready1), .ic_rdata(ic_rdata1),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready1), .dc_rdata(dc_rdata1),
    .mem_addr(mem_addr1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
    .mem_we(mem_we1), .mem_rdata(mem_rdata1));

  function automatic logic [127:0] init_line(input int a);
    return {32'h0000000A + 32'(a), 32'h5A5A0000 | 32'(a),
            32'hC3C3C3C3 ^ 32'(a), 32'h00000002 + 32'(a)};
  endfunction

  assign mem_rdata4 = mem4[mem_addr4[7:0]];
  assign mem_rdata1 = mem1[mem_addr1[7:0]];

  // Line memories: preload, then one-line write per mem_we cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem4[i] <= init_line(i);
        mem1[i] <= init_line(i);
      end
    end else begin
      if (mem_we4) mem4[mem_waddr4[7:0]] <= mem_wdata4;
      if (mem_we1) mem1[mem_waddr1[7:0]] <= mem_wdata1;
    end
  end

  // Observed outputs of whichever instance is under test
  wire          o_ic_ready  = sel1 ? ic_ready1  : ic_ready4;
  wire          o_dc_ready  = sel1 ? dc_ready1  : dc_ready4;
  wire          o_mem_we    = sel1 ? mem_we1    : mem_we4;
  wire [127:0]  o_ic_rdata  = sel1 ? ic_rdata1  : ic_rdata4;
  wire [127:0]  o_dc_rdata  = sel1 ? dc_rdata1  : dc_rdata4;
  wire [127:0]  o_mem_wdata = sel1 ? mem_wdata1 : mem_wdata4;
  wire [25:0]   o_mem_addr  = sel1 ? mem_addr1  : mem_addr4;
  wire [25:0]   o_mem_waddr = sel1 ? mem_waddr1 : mem_waddr4;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".mem_addr"},  128'(o_mem_addr),  128'd0);
    chk({tag, ".mem_waddr"}, 128'(o_mem_waddr), 128'd0);
    chk({tag, ".mem_wdata"}, o_mem_wdata,       128'd0);
    chk({tag, ".mem_we"},    128'(o_mem_we),    128'd0);
    chk({tag, ".ic_ready"},  128'(o_ic_ready),  128'd0);
    chk({tag, ".dc_ready"},  128'(o_dc_ready),  128'd0);
    chk({tag, ".ic_rdata"},  o_ic_rdata,        128'd0);
    chk({tag, ".dc_rdata"},  o_dc_rdata,        128'd0);
  endtask

  // Called at an IDLE-cycle negedge; the transaction described is the one the
  // model says is granted at the next posedge. Ends at the following IDLE negedge.
  task automatic expect_txn(input bit is_ic, input bit we, input logic [7:0] a,
                            input logic [127:0] wd, input bit scramble, input bit drop);
    int lat;
    logic [127:0] line;
    logic [127:0] exp_a;
    lat  = sel1 ? 1 : 4;
    line = we ? 128'd0 : ref_mem[a];
    for (int s = 1; s <= lat + 1; s++) begin
      @(negedge clk);
      if (s == 1 && scramble) begin
        if (is_ic) begin
          ic_addr = 26'($urandom_range(0, 255));
        end else begin
          dc_addr  = 26'($urandom_range(0, 255));
          dc_wdata = {4{$urandom()}};
          dc_we    = ~dc_we;
        end
      end
      exp_a = (s <= lat) ? 128'(a) : 128'd0;
      chk("txn.mem_addr",  128'(o_mem_addr),  exp_a);
      chk("txn.mem_waddr", 128'(o_mem_waddr), exp_a);
      chk("txn.mem_we",    128'(o_mem_we),    128'(we && s == lat));
      if (we && s == lat) chk("txn.mem_wdata", o_mem_wdata, wd);
      chk("txn.ic_ready", 128'(o_ic_ready), 128'(is_ic && s == lat + 1));
      chk("txn.dc_ready", 128'(o_dc_ready), 128'(!is_ic && s == lat + 1));
      if (s == lat + 1) begin
        if (is_ic) chk("txn.ic_rdata", o_ic_rdata, line);
        else       chk("txn.dc_rdata", o_dc_rdata, line);
        if (drop) begin
          if (is_ic) ic_req = 1'b0;
          else       dc_req = 1'b0;
        end
      end
    end
    if (we) ref_mem[a] = wd;
    last_dc = !is_ic;
    @(negedge clk);
    chk("txn.idle_mem_addr", 128'(o_mem_addr), 128'd0);
    chk("txn.idle_mem_we",   128'(o_mem_we),   128'd0);
    chk("txn.idle_ready",    128'({o_ic_ready, o_dc_ready}), 128'd0);
  endtask

  task automatic rand_txns(input int n);
    int pat;
    logic [7:0] ia, da;
    bit dw;
    logic [127:0] dd;
    for (int k = 0; k < n; k++) begin
      pat = $urandom_range(0, 2);
      ia  = 8'($urandom_range(0, 255));
      da  = 8'($urandom_range(0, 255));
      dw  = 1'($urandom_range(0, 1));
      dd  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ic_req = (pat != 1); ic_addr = 26'(ia);
      dc_req = (pat != 0); dc_addr = 26'(da); dc_we = dw; dc_wdata = dd;
      if (pat == 0) begin
        expect_txn(1'b1, 1'b0, ia, 128'd0, 1'b1, 1'b1);
      end else if (pat == 1) begin
        expect_txn(1'b0, dw, da, dd, 1'b1, 1'b1);
      end else if (last_dc) begin
        expect_txn(1'b1, 1'b0, ia, 128'd0, 1'b1, 1'b1);
        expect_txn(1'b0, dw, da, dd, 1'b1, 1'b1);
      end else begin
        expect_txn(1'b0, dw, da, dd, 1'b1, 1'b1);
        expect_txn(1'b1, 1'b0, ia, 128'd0, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic do_reset();
    if (sel1) reset1 = 1'b1;
    else      reset4 = 1'b1;
    @(negedge clk);
    reset4 = sel1;
    reset1 = !sel1;
    last_dc = 1'b1;
  endtask

  initial begin
    preload = 1'b1; reset4 = 1'b1; reset1 = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = 26'd0; dc_addr = 26'd0; dc_wdata = 128'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_line(i);
    last_dc = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check_idle("reset");
    reset4 = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // IC read alone, line 0
    ic_req = 1'b1; ic_addr = 26'd0;
    expect_txn(1'b1, 1'b0, 8'h00, 128'd0, 1'b0, 1'b1);

    // Simultaneous requests right after reset: IC first, DC 0x20 next
    do_reset();
    ic_req = 1'b1; ic_addr = 26'h5;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 26'h20;
    expect_txn(1'b1, 1'b0, 8'h05, 128'd0, 1'b0, 1'b1);
    expect_txn(1'b0, 1'b0, 8'h20, 128'd0, 1'b0, 1'b1);

    // DC write then IC read-back
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 26'h10; dc_wdata = {4{32'hDEAD_BEEF}};
    expect_txn(1'b0, 1'b1, 8'h10, {4{32'hDEAD_BEEF}}, 1'b0, 1'b1);
    ic_req = 1'b1; ic_addr = 26'h10;
    expect_txn(1'b1, 1'b0, 8'h10, 128'd0, 1'b0, 1'b1);
    chk("readback_pattern", ref_mem[8'h10], {4{32'hDEAD_BEEF}});

    // Round-robin with both requests held for four transactions
    do_reset();
    ic_req = 1'b1; ic_addr = 26'h3;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 26'h4;
    for (int k = 0; k < 4; k++) begin
      chk("rr_order", 128'(!last_dc), 128'(k % 2));
      if (last_dc) expect_txn(1'b1, 1'b0, 8'h03, 128'd0, 1'b0, 1'b0);
      else         expect_txn(1'b0, 1'b0, 8'h04, 128'd0, 1'b0, 1'b0);
    end
    ic_req = 1'b0; dc_req = 1'b0;

    // Reset in the middle of a DC write
    @(negedge clk);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 26'h30; dc_wdata = {4{32'h1234_5678}};
    @(negedge clk);
    chk("rstw.s1_waddr", 128'(o_mem_waddr), 128'h30);
    chk("rstw.s1_we",    128'(o_mem_we),    128'd0);
    @(negedge clk);
    chk("rstw.s2_we",    128'(o_mem_we),    128'd0);
    reset4 = 1'b1; dc_req = 1'b0;
    @(negedge clk);
    check_idle("rstw.after");
    reset4 = 1'b0; last_dc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstw.no_we",    128'(o_mem_we),   128'd0);
      chk("rstw.no_ready", 128'(o_dc_ready), 128'd0);
    end
    chk("rstw.mem_unchanged", mem4[8'h30], ref_mem[8'h30]);
    dc_req = 1'b1;
    expect_txn(1'b0, 1'b1, 8'h30, {4{32'h1234_5678}}, 1'b0, 1'b1);
    ic_req = 1'b1; ic_addr = 26'h30;
    expect_txn(1'b1, 1'b0, 8'h30, 128'd0, 1'b0, 1'b1);

    rand_txns(30);

    // Switch to the latency-1 instance
    reset4 = 1'b1; sel1 = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_line(i);
    @(negedge clk);
    check_idle("lat1.reset");
    reset1 = 1'b0; last_dc = 1'b1;
    @(negedge clk);
    ic_req = 1'b1; ic_addr = 26'h7;
    expect_txn(1'b1, 1'b0, 8'h07, 128'd0, 1'b0, 1'b1);
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 26'h9;
    expect_txn(1'b0, 1'b0, 8'h09, 128'd0, 1'b0, 1'b1);
    rand_txns(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer placed in front of the single-port line-wide main memory. It takes instruction-cache refill requests and data-cache refill/write-back requests and grants them round-robin. It emulates a fixed main-memory latency, drives the memory's read-address, write-address, write-data and write-enable pins, and returns a one-cycle `ready` pulse with the 128-bit line to the winning requester.

## Interface
- `ADDR_W`, 26, line address width (matches memory line address)
- `LINE_W`, 128, cache line width
- `MEM_LATENCY`, 4, BUSY cycles per transaction; legal 1..15

- `clk` in 1, clock
- `reset` in 1, reset, synchronous, active-high
- `ic_req` in 1, icache read request; held until `ic_ready`
- `ic_addr` in ADDR_W, icache line address
- `ic_ready` out 1, one-cycle completion pulse
- `ic_rdata` out LINE_W, line data, valid while `ic_ready`=1
- `dc_req` in 1, dcache request; held until `dc_ready`
- `dc_we` in 1, 1=write line, 0=read line
- `dc_addr` in ADDR_W, dcache line address
- `dc_wdata` in LINE_W, write line
- `dc_ready` out 1, one-cycle completion pulse
- `dc_rdata` out LINE_W, read line; 0 for writes
- `mem_addr` out ADDR_W, to memory read address
- `mem_waddr` out ADDR_W, to memory write address
- `mem_wdata` out LINE_W, to memory write data
- `mem_we` out 1, to memory write enable
- `mem_rdata` in LINE_W, from memory read data (combinational)

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Request present: grant it. Latch id, addr, we (forced 0 for ic), and wdata. Set `cnt`=MEM_LATENCY-1 and go to BUSY.
- Arbitration:
  - A single requester is granted directly.
  - When both requesters are present, grant the one not in `last_grant`. Update `last_grant` on every grant.
  - `last_grant` resets to DC, so IC wins the first tie.
- BUSY:
  - Drive `mem_addr`, `mem_waddr` and `mem_wdata` from the latched values.
  - Decrement `cnt`.
  - On the cycle with `cnt`=0:
    - Assert `mem_we` if latched we=1. This is exactly one cycle per write.
    - Capture `mem_rdata` into the response register, or capture 0 for a write.
    - Go to RESP.
- RESP: pulse the granted requester's `ready` with the response register on its `rdata`, then go to IDLE.
- Outside BUSY, `mem_addr`, `mem_waddr`, `mem_wdata` and `mem_we` are 0.
- Outputs decode only from state and latched registers. There is no combinational path from `*_req`, `*_addr` or `*_wdata` to any output.
- Requests are sampled only in IDLE. A `req` still high in the cycle after `ready` is treated as a new request.
- Requester inputs change after grant: latched values are used, so changes have no effect.
- Reset values:
  - state=IDLE, `cnt`=0, `last_grant`=DC.
  - All outputs 0, response register 0.
- Reset mid-transaction:
  - The in-flight transaction is dropped. No `ready` is issued.
  - No write occurs unless its `mem_we` cycle already completed before the reset edge.
  - The requester must reissue.

## Timing
- Request seen in IDLE at cycle t:
  - BUSY runs from t+1 to t+MEM_LATENCY.
  - `mem_we` and data capture happen at t+MEM_LATENCY.
  - `ready` pulses at t+MEM_LATENCY+1.
  - IDLE is reached at t+MEM_LATENCY+2, and the next grant can be taken in that cycle.
- Request-to-ready latency: MEM_LATENCY+1 cycles. Throughput: one transaction per MEM_LATENCY+2 cycles.
- The losing requester waits the full transaction. Its grant comes in the IDLE cycle following the winner's RESP.
- The counter is 4 bits wide. `MEM_LATENCY`=1 gives a single BUSY cycle with `cnt`=0.

## Structure
- The shared package `mem_pkg` holds:
  - `ADDR_W` and `LINE_W` constants.
  - `arb_state_t` enum: IDLE, BUSY, RESP.
  - `req_id_t` enum: REQ_IC, REQ_DC.
- There is no sub-module. The round-robin decision is a few lines inline.

## Test plan
- **IC read alone:** MEM_LATENCY=4, memory line 0 preloaded with 0x...0A_...02, `ic_req` at t. Required response:
  - `mem_addr`=0 during t+1..t+4.
  - `ic_ready`=1 only at t+5, with `ic_rdata` equal to the line.
  - `mem_we` stays 0 throughout.
- **Simultaneous requests after reset:** `ic_req` and `dc_req` (read 0x20) both at t. Required response:
  - IC is granted first and `ic_ready` pulses at t+5.
  - DC is granted at t+6 and `dc_ready` pulses at t+11 with line 0x20.
- **DC write then read-back:** DC write, addr 0x10, wdata 128'hDEAD_BEEF repeated. Required response:
  - `mem_we`=1 for exactly one cycle, at t+4, with `mem_waddr`=0x10.
  - `dc_ready` pulses at t+5 with `dc_rdata`=0.
  - A following IC read of 0x10 returns the written pattern.
- **Round-robin fairness:** both `req` held high for 4 transactions. Required response: grants go IC, DC, IC, DC, and no `ready` goes to the wrong port.
- **Reset mid-write:** reset asserted at t+2 of a DC write. Required response:
  - No `mem_we` and no `dc_ready`.
  - State is IDLE with all outputs 0 the next cycle.
  - The memory line is unchanged.
  - A reissued write completes normally.
- **Minimum latency:** MEM_LATENCY=1, IC read at t. Required response: BUSY only at t+1, `ic_ready` at t+2, next grant possible at t+3.
